regfile_access_ctrl: RTL and testbench

Sequencer and arbiter for the 32-entry register file's single access port. It serialises read-pair fetches and single writes from two requesters, the core pipeline (`c_`, priority) and the debug/loader port (`d_`, starvation-protected). It drives the regfile's fetch, write and write-enable strobes with correct per-cycle timing. It captures fetched data in the only cycle it is valid, because the regfile zeroes its read outputs in any idle cycle.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_arb_prio.sv | 33 +++
 rtl/regfile_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, sequencer states and requester ids for the regfile access controller
package regfile_pkg;

    localparam int DataSize = 32;
    localparam int AddrSize = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_arb_prio.sv
// regfile_arb_prio: core-priority arbiter with a starve counter that eventually lets debug through
module regfile_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arb_en,
    input  logic       c_valid,
    input  logic       d_valid,
    output logic [1:0] grant
);

    logic [3:0] starve_cnt;
    logic       starved;

    // Core wins by default; debug wins once it has watched STARVE_MAX core grants go by
    always_comb begin
        starved  = starve_cnt == 4'(STARVE_MAX);
        grant[1] = arb_en && d_valid && (!c_valid || starved);
        grant[0] = arb_en && c_valid && !grant[1];
    end

    // Count core grants made while debug is waiting; forget the history once debug is served or withdraws
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (!d_valid || grant[1])
            starve_cnt <= '0;
        else if (grant[0])
            starve_cnt <= starve_cnt + 4'd1;
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: serialises core/debug fetch-pair and write requests onto the regfile's single port
// Build option: REGFILE_ARB_R0_GUARD_EN suppresses the write enable for writes to r0.
module regfile_access_ctrl #(
    parameter int DataSize   = regfile_pkg::DataSize,
    parameter int AddrSize   = regfile_pkg::AddrSize,
    parameter int STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                c_req_valid,
    output logic                c_req_ready,
    input  logic                c_req_write,
    input  logic [AddrSize-1:0] c_rd_addr1,
    input  logic [AddrSize-1:0] c_rd_addr2,
    input  logic [AddrSize-1:0] c_wr_addr,
    input  logic [DataSize-1:0] c_wr_data,
    output logic                c_resp_valid,
    input  logic                c_resp_ready,
    output logic [DataSize-1:0] c_resp_data1,
    output logic [DataSize-1:0] c_resp_data2,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_write,
    input  logic [AddrSize-1:0] d_rd_addr1,
    input  logic [AddrSize-1:0] d_rd_addr2,
    input  logic [AddrSize-1:0] d_wr_addr,
    input  logic [DataSize-1:0] d_wr_data,
    output logic                d_resp_valid,
    input  logic                d_resp_ready,
    output logic [DataSize-1:0] d_resp_data1,
    output logic [DataSize-1:0] d_resp_data2,
    output logic [AddrSize-1:0] rf_read_addr1,
    output logic [AddrSize-1:0] rf_read_addr2,
    output logic [AddrSize-1:0] rf_write_addr,
    output logic [DataSize-1:0] rf_write_data,
    output logic                rf_do_fetch,
    output logic                rf_do_write,
    output logic                rf_write_en,
    input  logic [DataSize-1:0] rf_read_data1,
    input  logic [DataSize-1:0] rf_read_data2
);

    import regfile_pkg::*;

    state_t        state_q, state_d;
    req_id_t       owner_q;
    logic [1:0]    grant;
    logic          arb_en;
    logic          grant_write;
    logic          owner_ready;
    logic [AddrSize-1:0] rd_addr1_q, rd_addr2_q, wr_addr_q;
    logic [DataSize-1:0] wr_data_q;

    // Grants only happen from IDLE, and never while reset is held so req_ready reads 0 during reset
    assign arb_en      = state_q == IDLE && !reset;
    assign grant_write = grant[1] ? d_req_write : c_req_write;
    assign owner_ready = owner_q == DBG ? d_resp_ready : c_resp_ready;
    assign c_req_ready = grant[0];
    assign d_req_ready = grant[1];

    regfile_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .arb_en  (arb_en),
        .c_valid (c_req_valid),
        .d_valid (d_req_valid),
        .grant   (grant)
    );

    // Sequence each accepted request through its fixed-latency access phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|grant) state_d = grant_write ? WRITE : FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            WRITE:   state_d = IDLE;
            RESP:    if (owner_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons whatever access was in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Latch the winner's request fields so the requester may move on after its ready
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q    <= CORE;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else if (|grant) begin
            owner_q    <= grant[1] ? DBG : CORE;
            rd_addr1_q <= grant[1] ? d_rd_addr1 : c_rd_addr1;
            rd_addr2_q <= grant[1] ? d_rd_addr2 : c_rd_addr2;
            wr_addr_q  <= grant[1] ? d_wr_addr : c_wr_addr;
            wr_data_q  <= grant[1] ? d_wr_data : c_wr_data;
        end
    end

    // Capture regfile data in CAPTURE, the only cycle it is valid, and hold it until the owner consumes it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_resp_valid <= 1'b0;
            c_resp_data1 <= '0;
            c_resp_data2 <= '0;
            d_resp_valid <= 1'b0;
            d_resp_data1 <= '0;
            d_resp_data2 <= '0;
        end else begin
            if (state_q == CAPTURE && owner_q == CORE) begin
                c_resp_valid <= 1'b1;
                c_resp_data1 <= rf_read_data1;
                c_resp_data2 <= rf_read_data2;
            end else if (state_q == RESP && owner_q == CORE && c_resp_ready) begin
                c_resp_valid <= 1'b0;
            end
            if (state_q == CAPTURE && owner_q == DBG) begin
                d_resp_valid <= 1'b1;
                d_resp_data1 <= rf_read_data1;
                d_resp_data2 <= rf_read_data2;
            end else if (state_q == RESP && owner_q == DBG && d_resp_ready) begin
                d_resp_valid <= 1'b0;
            end
        end
    end

    assign rf_read_addr1 = rd_addr1_q;
    assign rf_read_addr2 = rd_addr2_q;
    assign rf_write_addr = wr_addr_q;
    assign rf_write_data = wr_data_q;
    assign rf_do_fetch   = state_q == FETCH;
    assign rf_do_write   = state_q == WRITE;
`ifdef REGFILE_ARB_R0_GUARD_EN
    assign rf_write_en   = state_q == WRITE && wr_addr_q != '0;
`else
    assign rf_write_en   = state_q == WRITE;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed vector bench for the regfile access controller with a behavioural regfile
module tb_regfile_access_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        c_req_valid = 0, c_req_write = 0, c_resp_ready = 1;
    logic        d_req_valid = 0, d_req_write = 0, d_resp_ready = 1;
    logic [4:0]  c_rd_addr1 = 0, c_rd_addr2 = 0, c_wr_addr = 0;
    logic [4:0]  d_rd_addr1 = 0, d_rd_addr2 = 0, d_wr_addr = 0;
    logic [31:0] c_wr_data = 0, d_wr_data = 0;
    logic        c_req_ready, d_req_ready, c_resp_valid, d_resp_valid;
    logic [31:0] c_resp_data1, c_resp_data2, d_resp_data1, d_resp_data2;
    logic [4:0]  rf_read_addr1, rf_read_addr2, rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_do_fetch, rf_do_write, rf_write_en;
    logic [31:0] rf_read_data1 = 0, rf_read_data2 = 0;
    logic [31:0] mem [32] = '{default: '0};
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    regfile_access_ctrl #(.DataSize(32), .AddrSize(5), .STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_write(c_req_write),
        .c_rd_addr1(c_rd_addr1), .c_rd_addr2(c_rd_addr2), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .c_resp_valid(c_resp_valid), .c_resp_ready(c_resp_ready),
        .c_resp_data1(c_resp_data1), .c_resp_data2(c_resp_data2),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
        .d_rd_addr1(d_rd_addr1), .d_rd_addr2(d_rd_addr2), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_data1(d_resp_data1), .d_resp_data2(d_resp_data2),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_do_fetch(rf_do_fetch), .rf_do_write(rf_do_write),
        .rf_write_en(rf_write_en), .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
    );

    // Behavioural regfile: registered read outputs that read as zero after any non-fetch cycle
    always @(posedge clock) begin
        if (rf_do_write && rf_write_en) mem[rf_write_addr] <= rf_write_data;
        rf_read_data1 <= rf_do_fetch ? mem[rf_read_addr1] : '0;
        rf_read_data2 <= rf_do_fetch ? mem[rf_read_addr2] : '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request from one requester and return at the negedge of the cycle after acceptance
    task automatic issue(input logic dbg, input logic wr, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] wa, input logic [31:0] wd);
        bit got = 0;
        if (dbg) begin
            d_req_write = wr; d_rd_addr1 = a1; d_rd_addr2 = a2; d_wr_addr = wa; d_wr_data = wd; d_req_valid = 1;
        end else begin
            c_req_write = wr; c_rd_addr1 = a1; c_rd_addr2 = a2; c_wr_addr = wa; c_wr_data = wd; c_req_valid = 1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            got = dbg ? d_req_ready : c_req_ready;
            @(negedge clock);
        end
        c_req_valid = 0;
        d_req_valid = 0;
        chk("grant", 32'(got), 1);
    endtask

    task automatic do_write(input logic dbg, input logic [4:0] wa, input logic [31:0] wd,
                            input logic en, input string nm);
        issue(dbg, 1'b1, 5'd0, 5'd0, wa, wd);
        #1;
        chk({nm, " do_write"}, 32'(rf_do_write), 1);
        chk({nm, " write_en"}, 32'(rf_write_en), 32'(en));
        chk({nm, " write_addr"}, 32'(rf_write_addr), 32'(wa));
        chk({nm, " write_data"}, rf_write_data, wd);
        chk({nm, " no_fetch"}, 32'(rf_do_fetch), 0);
        @(negedge clock);
        #1;
        chk({nm, " do_write_one_cycle"}, 32'(rf_do_write), 0);
    endtask

    task automatic do_fetch(input logic dbg, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2, input string nm);
        int   n = 0;
        logic v = 0;
        issue(dbg, 1'b0, a1, a2, 5'd0, 32'd0);
        #1;
        chk({nm, " do_fetch"}, 32'(rf_do_fetch), 1);
        while (!v && n < 20) begin
            @(negedge clock);
            #1;
            n++;
            v = dbg ? d_resp_valid : c_resp_valid;
        end
        chk({nm, " resp_latency"}, 32'(n), 2);
        chk({nm, " data1"}, dbg ? d_resp_data1 : c_resp_data1, e1);
        chk({nm, " data2"}, dbg ? d_resp_data2 : c_resp_data2, e2);
        @(negedge clock);
    endtask

    typedef struct {
        logic        dbg;
        logic        wr;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t       vecs [8];
    logic [9:0] seq;
    int         ng;
    logic       ok;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd0,  5'd0, 5'd3,  32'h11,       32'h0,        32'h0};
        vecs[1] = '{1'b0, 1'b1, 5'd0,  5'd0, 5'd7,  32'h22,       32'h0,        32'h0};
        vecs[2] = '{1'b0, 1'b0, 5'd3,  5'd7, 5'd0,  32'h0,        32'h11,       32'h22};
        vecs[3] = '{1'b1, 1'b1, 5'd0,  5'd0, 5'd5,  32'hDEAD,     32'h0,        32'h0};
        vecs[4] = '{1'b0, 1'b0, 5'd5,  5'd3, 5'd0,  32'h0,        32'hDEAD,     32'h11};
        vecs[5] = '{1'b1, 1'b0, 5'd7,  5'd5, 5'd0,  32'h0,        32'h22,       32'hDEAD};
        vecs[6] = '{1'b1, 1'b1, 5'd0,  5'd0, 5'd31, 32'hCAFEBABE, 32'h0,        32'h0};
        vecs[7] = '{1'b0, 1'b0, 5'd31, 5'd0, 5'd0,  32'h0,        32'hCAFEBABE, 32'h0};

        c_req_valid = 1;
        #2;
        chk("reset req_ready", {30'd0, c_req_ready, d_req_ready}, 0);
        chk("reset resp_valid", {30'd0, c_resp_valid, d_resp_valid}, 0);
        chk("reset strobes", {29'd0, rf_do_fetch, rf_do_write, rf_write_en}, 0);
        chk("reset resp_data", c_resp_data1 | c_resp_data2 | d_resp_data1 | d_resp_data2, 0);
        c_req_valid = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].dbg, vecs[i].wa, vecs[i].wd, 1'b1, $sformatf("vec%0d", i));
            else
                do_fetch(vecs[i].dbg, vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
        end

        // Both requesters continuously valid: expect C,C,C,C,D,C,C,C,C,D
        c_req_write = 1; c_wr_addr = 5'd10; c_wr_data = 32'hA0;
        d_req_write = 1; d_wr_addr = 5'd11; d_wr_data = 32'hB0;
        c_req_valid = 1; d_req_valid = 1;
        seq = '0;
        ng = 0;
        for (int i = 0; i < 60 && ng < 10; i++) begin
            #1;
            chk("arb exclusive", 32'(c_req_ready & d_req_ready), 0);
            if (c_req_ready || d_req_ready) begin
                seq = {seq[8:0], d_req_ready};
                ng++;
            end
            @(negedge clock);
        end
        c_req_valid = 0; d_req_valid = 0;
        chk("arb grant_count", 32'(ng), 10);
        chk("arb order", 32'(seq), 32'b0000100001);
        @(negedge clock);
        @(negedge clock);

        // Response stall: owner holds resp_ready low while debug waits
        c_resp_ready = 0;
        issue(1'b0, 1'b0, 5'd3, 5'd5, 5'd0, 32'd0);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("stall resp_valid", 32'(c_resp_valid), 1);
        d_req_write = 1; d_wr_addr = 5'd12; d_wr_data = 32'h1234; d_req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            ok = c_resp_valid && !rf_do_fetch && !rf_do_write && !c_req_ready && !d_req_ready &&
                 c_resp_data1 == 32'h11 && c_resp_data2 == 32'hDEAD;
            chk($sformatf("stall cycle%0d", i), 32'(ok), 1);
            @(negedge clock);
        end
        c_resp_ready = 1;
        @(negedge clock);
        #1;
        chk("stall released resp_valid", 32'(c_resp_valid), 0);
        chk("stall released d_grant", 32'(d_req_ready), 1);
        @(negedge clock);
        d_req_valid = 0;
        #1;
        chk("stall d_write strobe", 32'(rf_do_write), 1);
        @(negedge clock);
        do_fetch(1'b1, 5'd12, 5'd3, 32'h1234, 32'h11, "after_stall");

        // Reset asserted while a fetch is in CAPTURE
        issue(1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 32'd0);
        @(negedge clock);
        c_req_write = 1; c_wr_addr = 5'd9; c_wr_data = 32'h99; c_req_valid = 1;
        #1 reset = 1;
        #1;
        chk("capreset req_ready", {30'd0, c_req_ready, d_req_ready}, 0);
        chk("capreset resp_valid", {30'd0, c_resp_valid, d_resp_valid}, 0);
        chk("capreset strobes", {29'd0, rf_do_fetch, rf_do_write, rf_write_en}, 0);
        chk("capreset resp_data", c_resp_data1 | c_resp_data2 | d_resp_data1 | d_resp_data2, 0);
        chk("capreset rf_addr", {17'd0, rf_read_addr1, rf_read_addr2, rf_write_addr}, 0);
        chk("capreset rf_wdata", rf_write_data, 0);
        @(negedge clock);
        #1;
        chk("capreset discarded", 32'(c_resp_valid), 0);
        reset = 0;
        #1;
        chk("postreset grant", 32'(c_req_ready), 1);
        @(negedge clock);
        c_req_valid = 0;
        #1;
        chk("postreset write strobe", 32'(rf_do_write), 1);
        @(negedge clock);
        do_fetch(1'b0, 5'd9, 5'd7, 32'h99, 32'h22, "postreset");

        // Write to r0, then read it back
`ifdef REGFILE_ARB_R0_GUARD_EN
        do_write(1'b0, 5'd0, 32'hFFFF, 1'b0, "r0");
        do_fetch(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, "r0_read");
`else
        do_write(1'b0, 5'd0, 32'hFFFF, 1'b1, "r0");
        do_fetch(1'b1, 5'd0, 5'd0, 32'hFFFF, 32'hFFFF, "r0_read");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
